// File: rtl/sik_pkg.sv
// Shared definitions for the SIK operand stack: opcodes, fault codes and default word width.
package sik_pkg;

    localparam int unsigned WORD = 16;

    typedef enum logic [2:0] {
        OpNop   = 3'd0,
        OpPush  = 3'd1,
        OpPop   = 3'd2,
        OpDup   = 3'd3,
        OpGet   = 3'd4,
        OpPut   = 3'd5,
        OpBinop = 3'd6,
        OpClear = 3'd7
    } stack_op_t;

    typedef enum logic [1:0] {
        ErrNone      = 2'd0,
        ErrOverflow  = 2'd1,
        ErrUnderflow = 2'd2,
        ErrBadIdx    = 2'd3
    } stack_err_t;

endpackage

// File: rtl/sik_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports, no reset.
module sik_stack_ram #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 256,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_a_i,
    output logic [Width-1:0] rdata_a_o,
    input  logic [AddrW-1:0] raddr_b_i,
    output logic [Width-1:0] rdata_b_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/sik_stack.sv
// Operand stack for the SIK core: stack pointer, fault tracking and registered TOS/NOS.
// Storage holds every live entry (address 0 = bottom); tos_q/nos_q mirror the top two.
module sik_stack
    import sik_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned IDXW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [IDXW-1:0]   idx,
    input  logic [WIDTH-1:0]  din,
    output logic              op_ready,
    output logic [WIDTH-1:0]  tos,
    output logic [WIDTH-1:0]  nos,
    output logic [IDXW:0]     depth,
    output logic              empty,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [IDXW:0] One     = (IDXW+1)'(1);
    localparam logic [IDXW:0] Two     = (IDXW+1)'(2);
    localparam logic [IDXW:0] Three   = (IDXW+1)'(3);
    localparam logic [IDXW:0] FullCnt = (IDXW+1)'(DEPTH);

    logic [IDXW:0]      depth_q, depth_d;
    logic [WIDTH-1:0]   tos_q, tos_d;
    logic [WIDTH-1:0]   nos_q, nos_d;
    logic               err_q, err_d;
    stack_err_t         code_q, code_d;

    stack_op_t          op_e;
    stack_err_t         fault;
    logic               accept;
    logic               has1, has2, has3, is_full, idx_ok;
    logic [IDXW:0]      idx_ext, get_pos, below2_pos, bin_pos;
    logic [IDXW-1:0]    get_addr, below2_addr;
    logic               we;
    logic [IDXW-1:0]    waddr;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   rdata_idx, rdata_below2;
    logic [WIDTH-1:0]   below2_val;

    always_comb begin
        op_e        = stack_op_t'(op);
        accept      = op_valid && (!err_q || op_e == OpClear);
        idx_ext     = {1'b0, idx};
        has1        = depth_q >= One;
        has2        = depth_q >= Two;
        has3        = depth_q >= Three;
        is_full     = depth_q == FullCnt;
        idx_ok      = idx_ext < depth_q;
        get_pos     = depth_q - idx_ext - One;
        below2_pos  = depth_q - Three;
        bin_pos     = depth_q - Two;
        get_addr    = get_pos[IDXW-1:0];
        below2_addr = below2_pos[IDXW-1:0];
        below2_val  = has3 ? rdata_below2 : '0;

        fault = ErrNone;
        case (op_e)
            OpPush:  if (is_full) fault = ErrOverflow;
            OpPop:   if (!has1) fault = ErrUnderflow;
            OpDup: begin
                if (!has1)        fault = ErrUnderflow;
                else if (is_full) fault = ErrOverflow;
            end
            OpGet: begin
                if (!idx_ok)      fault = ErrBadIdx;
                else if (is_full) fault = ErrOverflow;
            end
            OpPut:   if (!idx_ok) fault = ErrBadIdx;
            OpBinop: if (!has2) fault = ErrUnderflow;
            default: fault = ErrNone;
        endcase
    end

    always_comb begin
        depth_d = depth_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        err_d   = err_q;
        code_d  = code_q;
        we      = 1'b0;
        waddr   = depth_q[IDXW-1:0];
        wdata   = tos_q;

        if (accept) begin
            if (op_e == OpClear) begin
                depth_d = '0;
                tos_d   = '0;
                nos_d   = '0;
                err_d   = 1'b0;
                code_d  = ErrNone;
            end else if (fault != ErrNone) begin
                err_d  = 1'b1;
                code_d = fault;
            end else begin
                case (op_e)
                    OpPush, OpDup, OpGet: begin
                        we    = 1'b1;
                        waddr = depth_q[IDXW-1:0];
                        wdata = (op_e == OpPush) ? din :
                                (op_e == OpDup)  ? tos_q : rdata_idx;
                        depth_d = depth_q + One;
                        nos_d   = tos_q;
                        tos_d   = wdata;
                    end
                    OpPop: begin
                        depth_d = depth_q - One;
                        tos_d   = nos_q;
                        nos_d   = below2_val;
                    end
                    OpPut: begin
                        // The write lands before the pop, so an idx of 1 or 2 changes the new top two.
                        we      = 1'b1;
                        waddr   = get_addr;
                        wdata   = tos_q;
                        depth_d = depth_q - One;
                        tos_d   = (idx == IDXW'(1)) ? tos_q : nos_q;
                        nos_d   = !has3 ? '0 : (idx == IDXW'(2)) ? tos_q : rdata_below2;
                    end
                    OpBinop: begin
                        we      = 1'b1;
                        waddr   = bin_pos[IDXW-1:0];
                        wdata   = din;
                        depth_d = depth_q - One;
                        tos_d   = din;
                        nos_d   = below2_val;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
        end else begin
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    sik_stack_ram #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (get_addr),
        .rdata_a_o (rdata_idx),
        .raddr_b_i (below2_addr),
        .rdata_b_o (rdata_below2)
    );

    assign op_ready = !err_q;
    assign tos      = tos_q;
    assign nos      = nos_q;
    assign depth    = depth_q;
    assign empty    = depth_q == '0;
    assign full     = depth_q == FullCnt;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_sik_stack.sv
// Self-checking bench for sik_stack (DEPTH=4): directed steps then random ops against a queue model.
module tb_sik_stack;
    import sik_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [IW-1:0] idx = '0;
    logic [W-1:0]  din = '0;
    logic          op_ready, empty, full, err;
    logic [W-1:0]  tos, nos;
    logic [IW:0]   depth;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    sik_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .idx      (idx),
        .din      (din),
        .op_ready (op_ready),
        .tos      (tos),
        .nos      (nos),
        .depth    (depth),
        .empty    (empty),
        .full     (full),
        .err      (err),
        .err_code (err_code)
    );

    // Reference model: queue with index 0 = bottom of stack.
    logic [W-1:0] stk[$];
    bit           m_err;
    int           m_code;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_fault(input int c);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = c;
        end
    endfunction

    function automatic void m_apply(input bit v, input int o, input int i, input logic [W-1:0] d);
        int n;
        n = stk.size();
        if (!v) return;
        if (m_err && o != 7) return;
        case (o)
            1: if (n == D) m_fault(1); else stk.push_back(d);
            2: if (n < 1) m_fault(2); else void'(stk.pop_back());
            3: if (n < 1) m_fault(2); else if (n == D) m_fault(1); else stk.push_back(stk[n-1]);
            4: if (i >= n) m_fault(3); else if (n == D) m_fault(1); else stk.push_back(stk[n-1-i]);
            5: if (i >= n) m_fault(3); else begin stk[n-1-i] = stk[n-1]; void'(stk.pop_back()); end
            6: if (n < 2) m_fault(2); else begin
                void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(d);
            end
            7: begin stk.delete(); m_err = 1'b0; m_code = 0; end
            default: ;
        endcase
    endfunction

    task automatic check_all(input string ctx);
        int n;
        logic [W-1:0] et, en;
        n  = stk.size();
        et = (n >= 1) ? stk[n-1] : '0;
        en = (n >= 2) ? stk[n-2] : '0;
        chk({ctx, ".tos"},      32'(tos),      32'(et));
        chk({ctx, ".nos"},      32'(nos),      32'(en));
        chk({ctx, ".depth"},    32'(depth),    32'(n));
        chk({ctx, ".empty"},    32'(empty),    32'(n == 0));
        chk({ctx, ".full"},     32'(full),     32'(n == D));
        chk({ctx, ".err"},      32'(err),      32'(m_err));
        chk({ctx, ".err_code"}, 32'(err_code), 32'(m_code));
        chk({ctx, ".op_ready"}, 32'(op_ready), 32'(!m_err));
    endtask

    task automatic do_op(input string ctx, input int o, input int i, input logic [W-1:0] d,
                         input bit v = 1'b1);
        @(negedge clk);
        op_valid = v;
        op       = 3'(o);
        idx      = IW'(i);
        din      = d;
        @(posedge clk);
        #1;
        m_apply(v, o, i, d);
        check_all(ctx);
    endtask

    initial begin
        m_err  = 1'b0;
        m_code = 0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic push/pop
        do_op("push11", 1, 0, 16'h0011);
        do_op("push22", 1, 0, 16'h0022);
        do_op("push33", 1, 0, 16'h0033);
        do_op("pop",    2, 0, 16'h0);
        do_op("clr0",   7, 0, 16'h0);

        // Overflow, ignored op while faulted, clear
        for (int k = 0; k < 4; k++) do_op("fill", 1, 0, 16'(16'h0100 + k));
        do_op("ovf",      1, 0, 16'hdead);
        do_op("ign_pop",  2, 0, 16'h0);
        do_op("ign_push", 1, 0, 16'hbeef);
        do_op("clr1",     7, 0, 16'h0);

        // GET/PUT
        do_op("pA",   1, 0, 16'h000a);
        do_op("pB",   1, 0, 16'h000b);
        do_op("pC",   1, 0, 16'h000c);
        do_op("get2", 4, 2, 16'h0);
        do_op("put3", 5, 3, 16'h0);
        do_op("get2b", 4, 2, 16'h0);
        do_op("put1", 5, 1, 16'h0);
        do_op("put2", 5, 2, 16'h0);
        do_op("clr2", 7, 0, 16'h0);

        // BINOP and underflow
        do_op("p5",    1, 0, 16'h0005);
        do_op("p7",    1, 0, 16'h0007);
        do_op("bin",   6, 0, 16'h000c);
        do_op("bin_u", 6, 0, 16'h0099);
        do_op("clr3",  7, 0, 16'h0);

        // Bad index, and overflow on GET at full
        do_op("q1",    1, 0, 16'h0001);
        do_op("q2",    1, 0, 16'h0002);
        do_op("get_b", 4, 2, 16'h0);
        do_op("clr4",  7, 0, 16'h0);
        for (int k = 0; k < 4; k++) do_op("fill2", 1, 0, 16'(16'h0200 + k));
        do_op("get_ovf", 4, 3, 16'h0);
        do_op("clr5",  7, 0, 16'h0);
        do_op("empty_pop", 2, 0, 16'h0);
        do_op("clr6",  7, 0, 16'h0);
        do_op("novalid", 1, 0, 16'h5555, 1'b0);

        // Mid-cycle asynchronous reset
        do_op("r1", 1, 0, 16'h0aaa);
        do_op("r2", 1, 0, 16'h0bbb);
        do_op("r3", 1, 0, 16'h0ccc);
        @(negedge clk);
        op_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        stk.delete();
        m_err  = 1'b0;
        m_code = 0;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        do_op("post_rst", 1, 0, 16'h1234);

        // Random ops
        for (int s = 0; s < 400; s++) begin
            int o, i;
            bit v;
            o = int'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) o = 7;
            if (m_err && $urandom_range(0, 2) == 0) o = 7;
            i = int'($urandom_range(0, D - 1));
            v = ($urandom_range(0, 9) != 0);
            do_op("rand", o, i, 16'($urandom), v);
        end

        op_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
